// File: rtl/pfixed_to_pfloat_pkg.sv
// Shared definitions for the fixed-point to single-precision converter:
// FSM state encodings, exponent bias and the default fraction width.
package pfixed_to_pfloat_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ABS   = 3'd1,
        ST_NORM  = 3'd2,
        ST_ROUND = 3'd3,
        ST_DONE  = 3'd4
    } fsm_state_t;

    localparam int BIAS              = 127;
    localparam int FRAC_BITS_DEFAULT = 21;

endpackage

// File: rtl/pfixed_to_pfloat_if.sv
// Request/response bundle of the converter.
// Handshake: the requester raises BEGIN_FSM_FX with FIXED stable for one
// sampling edge while the block is idle; the block answers by holding
// ACK_FX high with RESULT valid until RST_FSM_FX returns it to idle.
interface pfixed_to_pfloat_if;
    logic        RST_FSM_FX;
    logic        BEGIN_FSM_FX;
    logic [31:0] FIXED;
    logic        ACK_FX;
    logic [31:0] RESULT;

    modport master (
        output RST_FSM_FX,
        output BEGIN_FSM_FX,
        output FIXED,
        input  ACK_FX,
        input  RESULT
    );

    modport slave (
        input  RST_FSM_FX,
        input  BEGIN_FSM_FX,
        input  FIXED,
        output ACK_FX,
        output RESULT
    );
endinterface

// File: rtl/fsm_fixed_float.sv
// Control FSM of the converter: sequences IDLE -> ABS -> NORM -> ROUND -> DONE,
// counts the normalisation shifts (k) and drives the registered acknowledge.
module fsm_fixed_float
    import pfixed_to_pfloat_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rst_fsm,
    input  logic       start,
    input  logic       op_zero,
    input  logic       mag_msb,
    output fsm_state_t state,
    output logic [4:0] k,
    output logic       ack
);

    // State, shift count and acknowledge all advance together on the clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            k     <= 5'd0;
            ack   <= 1'b0;
        end else if (rst_fsm) begin
            // Abort wins over everything, including a start request in IDLE.
            state <= ST_IDLE;
            ack   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    ack <= 1'b0;
                    if (start) begin
                        state <= ST_ABS;
                    end
                end
                ST_ABS: begin
                    k <= 5'd0;
                    if (op_zero) begin
                        state <= ST_DONE;
                        ack   <= 1'b1;
                    end else begin
                        state <= ST_NORM;
                    end
                end
                ST_NORM: begin
                    // One shift per cycle until the leading one reaches bit 31.
                    if (mag_msb) begin
                        state <= ST_ROUND;
                    end else begin
                        k <= k + 5'd1;
                    end
                end
                ST_ROUND: begin
                    state <= ST_DONE;
                    ack   <= 1'b1;
                end
                ST_DONE: begin
                    ack <= 1'b1;
                end
                default: begin
                    state <= ST_IDLE;
                    ack   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/pfixed_to_pfloat.sv
// Converts a signed 32-bit fixed-point value with FRAC_BITS fraction bits into
// an IEEE-754 single-precision word. Normalisation is iterative (one bit per
// cycle) and rounding is round-to-nearest-even.
module pfixed_to_pfloat
    import pfixed_to_pfloat_pkg::*;
#(
    parameter int FRAC_BITS = FRAC_BITS_DEFAULT
) (
    input  logic             CLK,
    input  logic             RST_FF,
    pfixed_to_pfloat_if.slave bus,
    output fsm_state_t       dbg_state
);

    // Exponent of a value whose leading one sits at bit 31 before any shift.
    localparam logic [7:0] EXP_TOP = 8'(BIAS + 31 - FRAC_BITS);

    fsm_state_t  state;
    logic [4:0]  k;
    logic        ack;
    logic [31:0] operand;
    logic        sign;
    logic [31:0] mag;
    logic [31:0] result_q;

    logic [31:0] mag_abs;
    logic        op_zero;
    logic        guard;
    logic        sticky;
    logic        round_up;
    logic [23:0] frac_sum;
    logic [7:0]  exp_field;

    fsm_fixed_float u_fsm (
        .clk     (CLK),
        .rst_n   (RST_FF),
        .rst_fsm (bus.RST_FSM_FX),
        .start   (bus.BEGIN_FSM_FX),
        .op_zero (op_zero),
        .mag_msb (mag[31]),
        .state   (state),
        .k       (k),
        .ack     (ack)
    );

    // Magnitude and rounding arithmetic; 0x80000000 negates to itself, which
    // is the correct unsigned magnitude.
    always_comb begin
        mag_abs   = operand[31] ? (~operand + 32'd1) : operand;
        op_zero   = (operand == 32'd0);
        guard     = mag[7];
        sticky    = |mag[6:0];
        round_up  = guard & (sticky | mag[8]);
        frac_sum  = {1'b0, mag[30:8]} + {23'd0, round_up};
        // A carry out of the fraction bumps the exponent; the fraction wraps to 0.
        exp_field = EXP_TOP - {3'd0, k} + {7'd0, frac_sum[23]};
    end

    // Datapath registers, stepped by the FSM state.
    always_ff @(posedge CLK or negedge RST_FF) begin
        if (!RST_FF) begin
            operand  <= 32'd0;
            sign     <= 1'b0;
            mag      <= 32'd0;
            result_q <= 32'd0;
        end else if (!bus.RST_FSM_FX) begin
            case (state)
                ST_IDLE: begin
                    if (bus.BEGIN_FSM_FX) begin
                        operand <= bus.FIXED;
                    end
                end
                ST_ABS: begin
                    sign <= operand[31];
                    mag  <= mag_abs;
                    if (op_zero) begin
                        result_q <= 32'd0;
                    end
                end
                ST_NORM: begin
                    if (!mag[31]) begin
                        mag <= {mag[30:0], 1'b0};
                    end
                end
                ST_ROUND: begin
                    result_q <= {sign, exp_field, frac_sum[22:0]};
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.ACK_FX  = ack;
    assign bus.RESULT  = result_q;
    assign dbg_state   = state;

endmodule

// File: tb/tb_pfixed_to_pfloat.sv
// Self-checking bench for pfixed_to_pfloat (FRAC_BITS=21): directed corner
// values, randomized operands, abort and asynchronous-reset scenarios.
module tb_pfixed_to_pfloat;
    import pfixed_to_pfloat_pkg::*;

    localparam int FRAC = 21;

    logic CLK    = 1'b0;
    logic RST_FF = 1'b0;
    fsm_state_t dbg_state;

    pfixed_to_pfloat_if bus ();

    pfixed_to_pfloat #(.FRAC_BITS(FRAC)) dut (
        .CLK       (CLK),
        .RST_FF    (RST_FF),
        .bus       (bus.slave),
        .dbg_state (dbg_state)
    );

    // Clock
    always #5 CLK = ~CLK;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    logic        ack_prev = 1'b0;
    logic [31:0] last_res = 32'd0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference: exact value mag * 2^-FRAC rounded to 24 significant bits, nearest-even.
    function automatic logic [31:0] model(input logic [31:0] fx, output int lat);
        longint v;
        longint m;
        longint q;
        longint rem;
        longint half;
        int     p;
        int     sh;
        int     e;
        logic   s;
        v = longint'($signed(fx));
        s = (v < 0);
        m = s ? -v : v;
        if (m == 0) begin
            lat = 1;
            return 32'd0;
        end
        p = 0;
        for (int i = 0; i < 32; i++) begin
            if (((m >> i) & 64'd1) != 0) p = i;
        end
        lat = (31 - p) + 3;
        if (p <= 23) begin
            q = m << (23 - p);
        end else begin
            sh   = p - 23;
            q    = m >> sh;
            rem  = m - (q << sh);
            half = longint'(1) << (sh - 1);
            if (rem > half || (rem == half && (q & 64'd1) == 1)) q = q + 1;
        end
        if (q == (longint'(1) << 24)) begin
            q = q >> 1;
            p = p + 1;
        end
        e = p - FRAC + 127;
        return {s, 8'(e), 23'(q)};
    endfunction

    // Monitor: on every rising ACK_FX pop the oldest expectation and compare.
    always @(negedge CLK) begin
        if (bus.ACK_FX === 1'b1 && ack_prev !== 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ack actual=%h required=none", bus.RESULT);
            end else begin
                check32("result", bus.RESULT, exp_q.pop_front());
            end
        end
        ack_prev <= bus.ACK_FX;
    end

    // Driver: issue one conversion, measure latency, check hold, then return to idle.
    task automatic convert(input logic [31:0] fx);
        int          lat_exp;
        int          n;
        bit          seen;
        logic [31:0] e;
        e = model(fx, lat_exp);
        @(negedge CLK);
        bus.FIXED        = fx;
        bus.BEGIN_FSM_FX = 1'b1;
        exp_q.push_back(e);
        @(posedge CLK);
        @(negedge CLK);
        // Operand and start changes after capture must have no effect.
        bus.FIXED        = $urandom;
        bus.BEGIN_FSM_FX = 1'($urandom_range(0, 1));
        seen = 1'b0;
        n    = 0;
        for (int i = 1; i <= 40 && !seen; i++) begin
            @(posedge CLK);
            @(negedge CLK);
            if (bus.ACK_FX === 1'b1) begin
                seen = 1'b1;
                n    = i;
            end else begin
                bus.FIXED        = $urandom;
                bus.BEGIN_FSM_FX = 1'($urandom_range(0, 1));
            end
        end
        bus.BEGIN_FSM_FX = 1'b0;
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL ack_timeout fixed=%h actual=no_ack required=ack_after_%0d", fx, lat_exp);
            void'(exp_q.pop_back());
        end else begin
            check32("latency", 32'(n), 32'(lat_exp));
            @(negedge CLK);
            @(negedge CLK);
            check32("ack_hold", {31'd0, bus.ACK_FX}, 32'd1);
            check32("result_hold", bus.RESULT, e);
        end
        bus.RST_FSM_FX = 1'b1;
        @(negedge CLK);
        bus.RST_FSM_FX = 1'b0;
        check32("ack_after_clear", {31'd0, bus.ACK_FX}, 32'd0);
        check32("state_after_clear", 32'(dbg_state), 32'(ST_IDLE));
        if (seen) check32("result_after_clear", bus.RESULT, e);
        last_res = e;
    endtask

    // Watchdog
    initial begin
        #2ms;
        $display("FAIL watchdog actual=running required=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
    end

    initial begin
        logic [31:0] fx;
        bus.RST_FSM_FX   = 1'b0;
        bus.BEGIN_FSM_FX = 1'b0;
        bus.FIXED        = 32'd0;

        // Reset state
        repeat (2) @(posedge CLK);
        #1;
        check32("reset_result", bus.RESULT, 32'd0);
        check32("reset_ack", {31'd0, bus.ACK_FX}, 32'd0);
        check32("reset_state", 32'(dbg_state), 32'(ST_IDLE));
        @(posedge CLK);
        #2 RST_FF = 1'b1;

        // Directed corners
        convert(32'h0020_0000);
        convert(32'hFFE0_0000);
        convert(32'h0000_0000);
        convert(32'h7FFF_FFFF);
        convert(32'h8000_0000);
        convert(32'h0100_0001);
        convert(32'h0000_0001);

        // Abort in NORM: no ack, RESULT unchanged
        @(negedge CLK);
        bus.FIXED        = 32'h0000_0001;
        bus.BEGIN_FSM_FX = 1'b1;
        @(negedge CLK);
        bus.BEGIN_FSM_FX = 1'b0;
        repeat (3) @(negedge CLK);
        check32("abort_in_norm", 32'(dbg_state), 32'(ST_NORM));
        bus.RST_FSM_FX = 1'b1;
        @(negedge CLK);
        bus.RST_FSM_FX = 1'b0;
        check32("abort_state", 32'(dbg_state), 32'(ST_IDLE));
        check32("abort_result", bus.RESULT, last_res);
        repeat (3) @(negedge CLK);
        check32("abort_ack", {31'd0, bus.ACK_FX}, 32'd0);

        // Abort and start together in IDLE: abort wins
        bus.FIXED        = 32'h0040_0000;
        bus.RST_FSM_FX   = 1'b1;
        bus.BEGIN_FSM_FX = 1'b1;
        @(negedge CLK);
        bus.RST_FSM_FX   = 1'b0;
        bus.BEGIN_FSM_FX = 1'b0;
        check32("rst_beats_begin", 32'(dbg_state), 32'(ST_IDLE));
        convert(32'h0060_0000);

        // Asynchronous reset mid-conversion
        @(negedge CLK);
        bus.FIXED        = 32'h0000_0100;
        bus.BEGIN_FSM_FX = 1'b1;
        @(negedge CLK);
        bus.BEGIN_FSM_FX = 1'b0;
        repeat (4) @(negedge CLK);
        #2 RST_FF = 1'b0;
        #1;
        check32("async_rst_result", bus.RESULT, 32'd0);
        check32("async_rst_ack", {31'd0, bus.ACK_FX}, 32'd0);
        check32("async_rst_state", 32'(dbg_state), 32'(ST_IDLE));
        @(posedge CLK);
        #2 RST_FF = 1'b1;
        convert(32'h0020_0000);

        // Randomized operands across all magnitudes
        for (int i = 0; i < 40; i++) begin
            fx = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 1) == 1) fx = -fx;
            if ($urandom_range(0, 15) == 0) fx = 32'd0;
            convert(fx);
        end

        repeat (3) @(negedge CLK);
        check32("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
